fetch_unit: RTL and testbench

- Instruction fetch stage of the RISC-V core: holds the program counter, issues word requests to instruction memory over a valid/ready handshake, and buffers returned instructions with their PCs for decode.
- Consumes the execute-stage redirects: the branch-taken result and jump requests.
- On a redirect it reloads the PC, flushes buffered instructions and silently discards responses still in flight.

---
 rtl/fetch_unit.sv | 116 +++++++++++
 tb/tb_fetch_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, valid/ready request issue to instruction memory and an in-order
// ring of {pc, instr} slots for decode, with redirect flush and stale-response discard.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jump_en,
  input  logic [31:0] jump_target,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        misalign_err
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  // Back-to-back redirects can stack stale responses beyond DEPTH.
  localparam int unsigned DW = CW + 3;
  localparam logic [CW-1:0] DepthC = CW'(DEPTH);

  logic [31:0]   pc_q, pc_d;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d, unfilled_q, unfilled_d;
  logic [DW-1:0] discard_q, discard_d;
  logic          misalign_q, misalign_d;
  logic [31:0]   slot_pc_q    [DEPTH];
  logic [31:0]   slot_instr_q [DEPTH];

  logic          redirect, alloc, pop, rsp_fill, rsp_drop;
  logic [31:0]   target;
  logic [CW-1:0] filled_cnt;
  logic [PW-1:0] fill_idx;

  always_comb begin
    redirect   = br_taken | jump_en;
    target     = br_taken ? br_target : jump_target;
    filled_cnt = count_q - unfilled_q;
    // Responses arrive in order, so the oldest unfilled slot sits just past the filled ones.
    fill_idx   = head_q + filled_cnt[PW-1:0];
    if_valid   = (filled_cnt != '0);
    if_instr   = slot_instr_q[head_q];
    if_pc      = slot_pc_q[head_q];
    pop        = if_valid & if_ready & ~redirect;
    // A pop frees a slot this cycle, letting a full ring keep one fetch per cycle.
    imem_req_valid = ~rst & ~redirect & ((count_q < DepthC) | pop);
    imem_req_addr  = pc_q;
    alloc      = imem_req_valid & imem_req_ready;
    rsp_drop   = imem_rsp_valid & (discard_q != '0);
    rsp_fill   = imem_rsp_valid & (discard_q == '0);
    misalign_err = misalign_q;
  end

  always_comb begin
    pc_d       = pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    unfilled_d = unfilled_q;
    discard_d  = discard_q;
    misalign_d = 1'b0;
    if (redirect) begin
      pc_d       = {target[31:2], 2'b00};
      head_d     = tail_q;
      count_d    = '0;
      unfilled_d = '0;
      discard_d  = discard_q + DW'(unfilled_q) - DW'(imem_rsp_valid);
      misalign_d = (target[1:0] != 2'b00);
    end else begin
      if (alloc) begin
        pc_d   = pc_q + 32'd4;
        tail_d = tail_q + PW'(1);
      end
      if (pop) head_d = head_q + PW'(1);
      count_d    = count_q + CW'(alloc) - CW'(pop);
      unfilled_d = unfilled_q + CW'(alloc) - CW'(rsp_fill);
      discard_d  = discard_q - DW'(rsp_drop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      unfilled_q <= '0;
      discard_q  <= '0;
      misalign_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        slot_pc_q[i]    <= '0;
        slot_instr_q[i] <= '0;
      end
    end else begin
      pc_q       <= pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      unfilled_q <= unfilled_d;
      discard_q  <= discard_d;
      misalign_q <= misalign_d;
      if (alloc) slot_pc_q[tail_q] <= pc_q;
      if (rsp_fill) slot_instr_q[fill_idx] <= imem_rsp_data;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: in-order memory model with optional response hold,
// decode stalls, redirects, misaligned jump and request backpressure.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        br_taken, jump_en;
  logic [31:0] br_target, jump_target;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid, if_ready;
  logic [31:0] if_instr, if_pc;
  logic        misalign_err;

  int          n_checks = 0;
  int          n_bad    = 0;
  int          acc_count;
  bit          mem_hold;
  logic [31:0] mq [$];

  fetch_unit #(.RESET_PC(32'h0), .DEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .br_taken       (br_taken),
    .br_target      (br_target),
    .jump_en        (jump_en),
    .jump_target    (jump_target),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .misalign_err   (misalign_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock: note acceptance before the edge, then present the next in-order response.
  task automatic tick();
    logic        acc;
    logic [31:0] acc_addr;
    #1;
    acc      = imem_req_valid & imem_req_ready;
    acc_addr = imem_req_addr;
    @(posedge clk);
    #1;
    if (acc) begin
      mq.push_back(acc_addr);
      acc_count++;
    end
    if (!mem_hold && mq.size() > 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = ~mq.pop_front();
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    #1;
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    br_taken       = 1'b0;
    jump_en        = 1'b0;
    br_target      = '0;
    jump_target    = '0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if_ready       = 1'b1;
    mem_hold       = 1'b0;
    mq.delete();
    #1;
    tick();
    rst       = 1'b0;
    acc_count = 0;
    #1;
  endtask

  task automatic wait_if_valid(input string tag, input int max_cycles);
    bit seen = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      if (if_valid) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check_eq(tag, 32'(seen), 32'd1);
  endtask

  initial begin
    rst = 1'b0;
    #1 rst = 1'b1;
    br_taken = 1'b0; jump_en = 1'b0; br_target = '0; jump_target = '0;
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0; if_ready = 1'b1;
    #1;
    check_eq("rst_if_valid", 32'(if_valid), 32'd0);
    check_eq("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check_eq("rst_req_addr", imem_req_addr, 32'h0);
    check_eq("rst_misalign", 32'(misalign_err), 32'd0);
    check_eq("rst_if_pc", if_pc, 32'h0);
    check_eq("rst_if_instr", if_instr, 32'h0);

    // Streaming: latency-1 memory, decode always ready.
    do_reset();
    check_eq("s_req0_valid", 32'(imem_req_valid), 32'd1);
    check_eq("s_req0_addr", imem_req_addr, 32'h0);
    tick();
    check_eq("s_req1_addr", imem_req_addr, 32'h4);
    check_eq("s_no_valid_yet", 32'(if_valid), 32'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      check_eq("s_if_valid", 32'(if_valid), 32'd1);
      check_eq("s_if_pc", if_pc, 32'(4 * i));
      check_eq("s_if_instr", if_instr, ~32'(4 * i));
      tick();
    end

    // Decode stall fills the ring with exactly DEPTH fetches.
    do_reset();
    if_ready = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check_eq("st_accepted", 32'(acc_count), 32'd2);
    check_eq("st_req_valid", 32'(imem_req_valid), 32'd0);
    check_eq("st_if_pc", if_pc, 32'h0);
    if_ready = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      check_eq("st_rel_valid", 32'(if_valid), 32'd1);
      check_eq("st_rel_pc", if_pc, 32'(4 * i));
      tick();
    end

    // Branch with two fetches in flight: both responses dropped.
    do_reset();
    mem_hold = 1'b1;
    tick();
    tick();
    check_eq("br_inflight", 32'(mq.size()), 32'd2);
    br_taken  = 1'b1;
    br_target = 32'h100;
    #1;
    check_eq("br_no_req", 32'(imem_req_valid), 32'd0);
    mem_hold = 1'b0;
    tick();
    br_taken = 1'b0;
    #1;
    check_eq("br_req_addr", imem_req_addr, 32'h100);
    check_eq("br_misalign", 32'(misalign_err), 32'd0);
    check_eq("br_drop0", 32'(if_valid), 32'd0);
    wait_if_valid("br_seen", 10);
    check_eq("br_if_pc", if_pc, 32'h100);
    check_eq("br_if_instr", if_instr, ~32'h100);

    // Branch wins over a simultaneous jump.
    do_reset();
    tick();
    tick();
    br_taken = 1'b1; br_target = 32'h40;
    jump_en  = 1'b1; jump_target = 32'h80;
    tick();
    br_taken = 1'b0; jump_en = 1'b0;
    #1;
    check_eq("pri_req_addr", imem_req_addr, 32'h40);
    wait_if_valid("pri_seen", 10);
    check_eq("pri_if_pc", if_pc, 32'h40);

    // Misaligned jump target: one-cycle error pulse, aligned restart.
    do_reset();
    tick();
    tick();
    jump_en = 1'b1; jump_target = 32'h202;
    #1;
    check_eq("mis_pre", 32'(misalign_err), 32'd0);
    tick();
    jump_en = 1'b0;
    #1;
    check_eq("mis_pulse", 32'(misalign_err), 32'd1);
    check_eq("mis_req_addr", imem_req_addr, 32'h200);
    tick();
    check_eq("mis_clear", 32'(misalign_err), 32'd0);
    wait_if_valid("mis_seen", 10);
    check_eq("mis_if_pc", if_pc, 32'h200);

    // Memory backpressure: address holds until accepted.
    do_reset();
    tick();
    tick();
    imem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("bp_valid", 32'(imem_req_valid), 32'd1);
      check_eq("bp_addr", imem_req_addr, 32'h8);
      tick();
    end
    imem_req_ready = 1'b1;
    #1;
    check_eq("bp_acc_addr", imem_req_addr, 32'h8);
    tick();
    check_eq("bp_next_addr", imem_req_addr, 32'hC);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
